// File: rtl/mii_rx_pkg.sv
// Shared definitions for the MII receive framer: FSM states and MII nibble codes.
package mii_rx_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRE,
    DATA,
    DROP
  } rx_state_e;

  localparam logic [3:0] PRE_NIB = 4'h5;
  localparam logic [3:0] SFD_NIB = 4'hD;

endpackage

// File: rtl/rx_stat_counter.sv
// 8-bit wrapping event counter with increment enable.
module rx_stat_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  output logic [7:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc) begin
      count <= count + 8'd1;
    end
  end

endmodule

// File: rtl/mii_rx_framer.sv
// MII receive front-end: strips preamble/SFD, assembles nibbles into a registered
// byte stream with last/error marking, and counts good and bad frames.
module mii_rx_framer
  import mii_rx_pkg::*;
#(
  parameter int MIN_PRE   = 4,
  parameter int MAX_BYTES = 1522
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_ce,
  input  logic       mii_rx_dv,
  input  logic       mii_rx_er,
  input  logic [3:0] mii_rxd,
  output logic [7:0] m_data,
  output logic       m_valid,
  output logic       m_last,
  output logic       m_err,
  output logic [7:0] frames_ok,
  output logic [7:0] frames_bad
);

  localparam int CNT_W = $clog2(MAX_BYTES + 1);
  localparam int PRE_W = $clog2(MIN_PRE + 1);

  rx_state_e        state;
  logic [PRE_W-1:0] pre_cnt;
  logic [3:0]       nib_lo;
  logic             nib_half;
  logic [7:0]       hold_byte;
  logic             hold_full;
  logic [CNT_W-1:0] byte_cnt;
  logic             err_sticky;

  logic byte_done, overflow, frame_end;
  logic emit, emit_last, emit_err;
  logic inc_ok, inc_bad;

  // Emission is decided combinationally so the counters step on the same edge
  // that registers m_last.
  always_comb begin
    byte_done = 1'b0;
    frame_end = 1'b0;
    if (rx_ce && state == DATA) begin
      byte_done = mii_rx_dv && nib_half;
      frame_end = !mii_rx_dv && hold_full;
    end
    overflow  = byte_done && (byte_cnt == CNT_W'(MAX_BYTES));
    emit      = (byte_done && hold_full) || frame_end || overflow;
    emit_last = overflow || frame_end;
    emit_err  = overflow || (frame_end && (err_sticky || nib_half || mii_rx_er));
    inc_ok    = emit && emit_last && !emit_err;
    inc_bad   = emit && emit_last && emit_err;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      pre_cnt    <= '0;
      nib_lo     <= '0;
      nib_half   <= 1'b0;
      hold_byte  <= '0;
      hold_full  <= 1'b0;
      byte_cnt   <= '0;
      err_sticky <= 1'b0;
      m_data     <= '0;
      m_valid    <= 1'b0;
      m_last     <= 1'b0;
      m_err      <= 1'b0;
    end else begin
      m_valid <= 1'b0;
      if (emit) begin
        m_valid <= 1'b1;
        m_data  <= hold_byte;
        m_last  <= emit_last;
        m_err   <= emit_err;
      end
      if (rx_ce) begin
        unique case (state)
          IDLE: begin
            if (mii_rx_dv) begin
              if (mii_rxd == PRE_NIB) begin
                state   <= PRE;
                pre_cnt <= PRE_W'(1);
              end else begin
                state <= DROP;
              end
            end
          end
          PRE: begin
            if (!mii_rx_dv) begin
              state <= IDLE;
            end else if (mii_rxd == PRE_NIB) begin
              if (pre_cnt < PRE_W'(MIN_PRE)) pre_cnt <= pre_cnt + PRE_W'(1);
            end else if (mii_rxd == SFD_NIB && pre_cnt >= PRE_W'(MIN_PRE)) begin
              state      <= DATA;
              nib_half   <= 1'b0;
              hold_full  <= 1'b0;
              byte_cnt   <= '0;
              err_sticky <= 1'b0;
            end else begin
              state <= DROP;
            end
          end
          DATA: begin
            if (overflow) begin
              state     <= DROP;
              hold_full <= 1'b0;
            end else if (!mii_rx_dv) begin
              state     <= IDLE;
              hold_full <= 1'b0;
              nib_half  <= 1'b0;
            end else begin
              if (mii_rx_er) err_sticky <= 1'b1;
              if (!nib_half) begin
                nib_lo   <= mii_rxd;
                nib_half <= 1'b1;
              end else begin
                hold_byte <= {mii_rxd, nib_lo};
                hold_full <= 1'b1;
                nib_half  <= 1'b0;
                byte_cnt  <= byte_cnt + CNT_W'(1);
              end
            end
          end
          DROP: begin
            if (!mii_rx_dv) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  rx_stat_counter u_ok_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (inc_ok),
    .count (frames_ok)
  );

  rx_stat_counter u_bad_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (inc_bad),
    .count (frames_bad)
  );

endmodule
